// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM state encodings, halt word and instruction field positions
package instr_fetch_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_t;
    localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;
    localparam int OPC_HI = 15, OPC_LO = 12;
    localparam int RD_HI  = 11, RD_LO  = 8;
    localparam int EXT_HI = 7,  EXT_LO = 4;
    localparam int RS_HI  = 3,  RS_LO  = 0;
    function automatic logic [3:0] opcode(input logic [15:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction
endpackage

// File: rtl/instr_fetch_pc_next.sv
// instr_fetch_pc_next: next program counter, branch target or sequential with natural wrap
module instr_fetch_pc_next #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] nxt
);
    assign nxt = pc_load ? pc_target : pc + ADDR_W'(1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 16-bit instruction words, holds each for the executor until retired
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       inop,
    output logic              inop_valid,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc_seq;
    logic retire, restart;

    assign retire  = state == ISSUE && exec_done;
    assign restart = (state == IDLE || state == HALT) && start;

    instr_fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc        (pc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .nxt       (pc_seq)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
            inop  <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT) inop <= mem_rdata;
            if (retire) pc <= pc_seq;
            else if (restart) pc <= '0;
        end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? FETCH : IDLE;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = mem_rdata == HALT_WORD ? HALT : ISSUE;
            ISSUE:   state_nxt = exec_done ? FETCH : ISSUE;
            HALT:    state_nxt = start ? FETCH : HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // every output is a decode of registered state only
    assign mem_addr   = pc;
    assign mem_re     = state == FETCH;
    assign inop_valid = state == ISSUE;
    assign busy       = state == FETCH || state == WAIT || state == ISSUE;
    assign halted     = state == HALT;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random program run against an instruction-level model of fetch/issue/halt
module tb_instr_fetch;
    logic        clk = 0, rst = 0, start = 0, exec_done = 0, pc_load = 0;
    logic [7:0]  pc_target = 0, mem_addr, pc;
    logic        mem_re, inop_valid, busy, halted;
    logic [15:0] mem_rdata = 0, inop;
    logic [15:0] mem [256];
    logic [7:0]  exp_pc;
    int          n_chk = 0, n_fail = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .inop(inop), .inop_valid(inop_valid), .exec_done(exec_done),
        .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // memory returns the addressed word one cycle after a read, noise otherwise
    always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 16'($urandom);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one instruction: entered at the FETCH cycle, left at the next FETCH cycle
    task automatic run_instr(input int dwell, input bit ld, input logic [7:0] tgt);
        logic [15:0] w;
        bit hit;
        w = mem[exp_pc];
        hit = w == 16'hFFFF;
        check("fetch_re", mem_re, 1);
        check("fetch_addr", mem_addr, exp_pc);
        check("fetch_valid", inop_valid, 0);
        exec_done = 1'($urandom); pc_load = 1'($urandom); pc_target = 8'($urandom);
        tick();
        check("wait_re", mem_re, 0);
        check("wait_busy", busy, 1);
        exec_done = 1'($urandom); pc_load = 1'($urandom);
        tick();
        exec_done = 0; pc_load = 0;
        check("halted", halted, hit);
        check("valid", inop_valid, !hit);
        check("inop", inop, w);
        check("pc", pc, exp_pc);
        if (hit) begin
            for (int i = 0; i < dwell; i++) begin
                exec_done = 1'($urandom); pc_load = 1'($urandom); pc_target = 8'($urandom);
                tick();
                check("halt_hold", halted, 1);
                check("halt_pc", pc, exp_pc);
            end
            exec_done = 0; pc_load = 0; start = 1;
            tick();
            start = 0;
            exp_pc = 0;
            check("restart_halted", halted, 0);
        end else begin
            for (int i = 0; i < dwell; i++) begin
                start = 1'($urandom); pc_load = 1'($urandom); pc_target = 8'($urandom);
                tick();
                check("dwell_inop", inop, w);
                check("dwell_valid", inop_valid, 1);
                check("dwell_pc", pc, exp_pc);
            end
            start = 0; exec_done = 1; pc_load = ld; pc_target = tgt;
            tick();
            exec_done = 0; pc_load = 0;
            exp_pc = ld ? tgt : exp_pc + 8'd1;
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'h0000;
        tick(); tick();
        check("rst_pc", pc, 0);
        check("rst_inop", inop, 0);
        check("rst_valid", inop_valid, 0);
        check("rst_re", mem_re, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        rst = 1;
        exec_done = 1; pc_load = 1; pc_target = 8'h55;
        tick(); tick(); tick();
        exec_done = 0; pc_load = 0;
        check("idle_busy", busy, 0);
        check("idle_pc", pc, 0);
        start = 1;
        tick();
        start = 0;
        exp_pc = 0;
        // short program ending in a halt word
        mem[0] = 16'h0153; mem[1] = 16'h5207; mem[2] = 16'hFFFF;
        run_instr(0, 0, 0);
        run_instr(0, 0, 0);
        run_instr(2, 0, 0);
        // branch, wrap from top of memory, long dwell
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[8'h40] = 16'h5555; mem[8'hFF] = 16'h6666;
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0);
        run_instr(0, 1, 8'h40);
        run_instr(0, 1, 8'hFF);
        run_instr(1, 0, 0);
        run_instr(10, 0, 0);
        // asynchronous reset mid-ISSUE drops the word and pc
        mem[1] = 16'h0153;
        check("pre_rst_addr", mem_addr, 1);
        tick(); tick();
        check("pre_rst_inop", inop, 16'h0153);
        rst = 0;
        #1;
        check("arst_pc", pc, 0);
        check("arst_inop", inop, 0);
        check("arst_valid", inop_valid, 0);
        check("arst_busy", busy, 0);
        tick();
        rst = 1;
        tick(); tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_halted", halted, 0);
        check("post_rst_re", mem_re, 0);
        foreach (mem[i]) mem[i] = ($urandom_range(0, 11) == 0) ? 16'hFFFF : 16'($urandom);
        mem[0] = 16'h0001;
        start = 1;
        tick();
        start = 0;
        exp_pc = 0;
        for (int n = 0; n < 300; n++)
            run_instr($urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
